// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, default byte width
// and the index-width helper used by the arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Index width that stays at least 1 bit for degenerate requester counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter side bundle of the UART transmit arbiter.
// master = producers plus transmitter, slave = arbiter.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF
);
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_REQ-1:0]             ack;
  logic                         busy;
  logic                         timeout_err;
  logic                         uart_start;
  logic [DATA_W-1:0]            uart_tx_data;
  logic                         uart_tx_done;

  modport master (
    output req, req_data, uart_tx_done,
    input  ack, busy, timeout_err, uart_start, uart_tx_data
  );

  modport slave (
    input  req, req_data, uart_tx_done,
    output ack, busy, timeout_err, uart_start, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward,
// wrapping modulo N_REQ. Produces a one-hot grant and its index.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int               k;
    logic [IDX_W-1:0] ki;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    k         = 0;
    ki        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      ki = IDX_W'(k);
      if (!grant_vld && req[ki]) begin
        grant_vld = 1'b1;
        grant[ki] = 1'b1;
        grant_idx = ki;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers: round-robin grant, byte latch,
// start strobe, then hold until the transmitter reports done or the watchdog aborts.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 120000
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int               IDX_W   = idx_w(N_REQ);
  localparam int               WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_REQ - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [WD_W-1:0]  wdog;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (bus.req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Next scan starts just past the requester that was served, so a held
  // request goes to the back of the line.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    return (i == IDX_TOP) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      win_idx          <= '0;
      wdog             <= '0;
      bus.ack          <= '0;
      bus.busy         <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.uart_start   <= 1'b0;
      bus.uart_tx_data <= '0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.ack <= '0;
          if (grant_vld) begin
            bus.ack          <= grant;
            bus.uart_tx_data <= bus.req_data[grant_idx];
            win_idx          <= grant_idx;
            bus.busy         <= 1'b1;
            state            <= ST_START;
          end
        end
        ST_START: begin
          bus.ack        <= '0;
          bus.uart_start <= 1'b1;
          wdog           <= '0;
          state          <= ST_WAIT;
        end
        ST_WAIT: begin
          bus.uart_start <= 1'b0;
          if (wdog != '1) wdog <= wdog + 1'b1;
          // Done takes priority over a coincident watchdog expiry.
          if (bus.uart_tx_done) begin
            rr_ptr   <= next_ptr(win_idx);
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else if (wdog == WD_LAST) begin
            rr_ptr          <= next_ptr(win_idx);
            bus.timeout_err <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: begin
          bus.ack        <= '0;
          bus.uart_start <= 1'b0;
          bus.busy       <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: directed grants pushed as expectations,
// a monitor pops and checks each ack/start, plus a simple transmitter done model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N = 4, W = 8, TO = 50, DONE_DLY = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {int idx; logic [W-1:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int   errors = 0, checks = 0, to_cnt = 0, cd = 0, k = 0;
  logic model_done = 1'b0, man_done = 1'b0, done_en = 1'b0;
  assign bus.uart_tx_done = model_done | man_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Transmitter model: done pulse DONE_DLY cycles after each start strobe.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!reset) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) model_done = 1'b1;
      end
      if (done_en && bus.uart_start) cd = DONE_DLY;
    end
  end

  // Monitor: every ack pops one expectation; start must follow ack with that byte,
  // and the byte must hold until busy drops.
  logic         pend = 1'b0, hold = 1'b0, prev_ack = 1'b0;
  logic [W-1:0] pend_data = '0, hold_data = '0;
  always @(negedge clk) begin
    if (!reset) begin
      pend = 1'b0; hold = 1'b0; prev_ack = 1'b0;
    end else begin
      if (bus.timeout_err) to_cnt++;
      if (bus.ack != '0) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'(bus.ack), 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("ack_onehot", 32'(bus.ack), 32'(1) << mon_e.idx);
          pend = 1'b1; pend_data = mon_e.data;
        end
      end
      if (bus.uart_start) begin
        chk("start_after_ack", 32'(prev_ack), 1);
        chk("start_data", 32'(bus.uart_tx_data), 32'(pend_data));
        hold = 1'b1; hold_data = pend_data; pend = 1'b0;
      end else if (hold) begin
        if (bus.busy) chk("data_stable", 32'(bus.uart_tx_data), 32'(hold_data));
        else hold = 1'b0;
      end
      prev_ack = (bus.ack != '0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_acks(input int n, input string name);
    int seen = 0, t = 0;
    while (seen < n && t < 500) begin
      @(negedge clk); t++;
      if (bus.ack != '0) seen++;
    end
    chk(name, seen, n);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while (bus.busy && t < 500) begin
      @(negedge clk); t++;
    end
    chk(name, 32'(bus.busy), 0);
  endtask

  initial begin
    reset = 1'b0; bus.req = '0; bus.req_data = '0;

    // Reset values, then still idle after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_start", 32'(bus.uart_start), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_data", 32'(bus.uart_tx_data), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    reset = 1'b1;
    cyc(3);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_ack", 32'(bus.ack), 0);

    // Single requester
    done_en = 1'b1;
    exp_q.push_back('{1, 8'hA3});
    bus.req_data[1] = 8'hA3; bus.req = 4'b0010;
    wait_acks(1, "t2_ack");
    bus.req = '0;
    chk("t2_busy", 32'(bus.busy), 1);
    wait_idle("t2_idle");

    // Fresh pointer, all requesting: 0,1,2,3,0
    reset = 1'b0; cyc(1); reset = 1'b1; cyc(1);
    for (int i = 0; i < N; i++) bus.req_data[i] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++) exp_q.push_back('{i % N, 8'(8'h10 + i % N)});
    bus.req = 4'b1111;
    wait_acks(5, "t3_acks");
    bus.req = '0;
    wait_idle("t3_idle");

    // Move pointer to 3, then 3 beats 0
    exp_q.push_back('{2, 8'h5C});
    bus.req_data[2] = 8'h5C; bus.req = 4'b0100;
    wait_acks(1, "t4a_ack"); bus.req = '0; wait_idle("t4a_idle");
    exp_q.push_back('{3, 8'h73});
    exp_q.push_back('{0, 8'h70});
    bus.req_data[0] = 8'h70; bus.req_data[3] = 8'h73; bus.req = 4'b1001;
    wait_acks(2, "t4b_acks"); bus.req = '0; wait_idle("t4b_idle");

    // Watchdog: no done, err exactly TO cycles after START exit
    done_en = 1'b0;
    exp_q.push_back('{0, 8'h81});
    bus.req_data[0] = 8'h81; bus.req = 4'b0001;
    wait_acks(1, "t5_ack"); bus.req = '0;
    @(negedge clk);
    chk("t5_start", 32'(bus.uart_start), 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.timeout_err && k < 200);
    chk("t5_to_latency", k, TO);
    chk("t5_busy_drop", 32'(bus.busy), 0);
    @(negedge clk);
    chk("t5_err_pulse", 32'(bus.timeout_err), 0);

    // Done on the timeout cycle wins
    exp_q.push_back('{1, 8'h92});
    bus.req_data[1] = 8'h92; bus.req = 4'b0010;
    wait_acks(1, "t5b_ack"); bus.req = '0;
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    chk("t5b_busy_before", 32'(bus.busy), 1);
    man_done = 1'b1; @(negedge clk); man_done = 1'b0;
    chk("t5b_no_err", 32'(bus.timeout_err), 0);
    chk("t5b_idle", 32'(bus.busy), 0);
    @(negedge clk);
    chk("t5b_no_err2", 32'(bus.timeout_err), 0);

    // Reset during WAIT
    exp_q.push_back('{2, 8'hC6});
    bus.req_data[2] = 8'hC6; bus.req = 4'b0100;
    wait_acks(1, "t6_ack"); bus.req = '0;
    cyc(5);
    chk("t6_pre_busy", 32'(bus.busy), 1);
    reset = 1'b0; #1;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_ack", 32'(bus.ack), 0);
    chk("t6_rst_start", 32'(bus.uart_start), 0);
    chk("t6_rst_data", 32'(bus.uart_tx_data), 0);
    cyc(2); reset = 1'b1; cyc(1);

    // Stray done in IDLE is ignored
    man_done = 1'b1; @(negedge clk); man_done = 1'b0;
    cyc(2);
    chk("stray_busy", 32'(bus.busy), 0);
    chk("stray_ack", 32'(bus.ack), 0);
    chk("stray_start", 32'(bus.uart_start), 0);

    // Pointer back at 0: requester 1 beats 2
    done_en = 1'b1;
    exp_q.push_back('{1, 8'hE1});
    bus.req_data[1] = 8'hE1; bus.req_data[2] = 8'hE2; bus.req = 4'b0110;
    wait_acks(1, "t6b_ack"); bus.req = '0; wait_idle("t6b_idle");

    chk("queue_drained", exp_q.size(), 0);
    chk("timeout_count", to_cnt, 1);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
